axis_fifo_buf: RTL and testbench
================================

Name: axis_fifo_buf

Overview:
- Synchronous AXI-Stream FIFO placed directly downstream of axis_reg.
- Consumes axis_reg's master stream and buffers up to DEPTH words to absorb sink backpressure bursts.
- Presents a first-word-fall-through AXI-Stream master to the next stage.
- Reports fill level for monitoring and test.

Parameters:
- DATA_W, 32, tdata width in bits.
- DEPTH, 8, number of storage words; power of two, >= 2.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- arstn_i  input  1  asynchronous active-low reset.
- s_axis_tdata_i  input  DATA_W  slave data from upstream stage.
- s_axis_tvalid_i  input  1  slave valid.
- s_axis_tready_o  output  1  slave ready; high when not full and out of reset.
- m_axis_tdata_o  output  DATA_W  master data; head of FIFO.
- m_axis_tvalid_o  output  1  master valid; high when not empty.
- m_axis_tready_i  input  1  master ready from downstream.
- level_o  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk_i. Reset arstn_i is asynchronous, active-low: assertion takes effect immediately, release is sampled on clk_i.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level_o = 0.
  - m_axis_tvalid_o = 0, m_axis_tdata_o = 0.
  - s_axis_tready_o = 0 (registered ready flag).
- Storage array is not reset.
- First rising edge after arstn_i release: s_axis_tready_o goes 1 (FIFO empty).
- Pointers: $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal, wrap bits differ).
  - Address wraps from DEPTH-1 to 0 with the wrap bit toggling.
- Push occurs when s_axis_tvalid_i && s_axis_tready_o at a rising edge. Data is written to mem[wr_ptr] and wr_ptr increments.
- Pop occurs when m_axis_tvalid_o && m_axis_tready_i at a rising edge; rd_ptr increments.
- s_axis_tready_o is a register: next value = !(next_level == DEPTH). It is never combinationally dependent on m_axis_tready_i, so there is no ready path through the block.
- m_axis_tvalid_o = (level_o != 0).
- m_axis_tdata_o = mem[rd_ptr] when valid, else 0 (forced zero while empty).
- Latency: a word pushed at edge N appears on the master at edge N+1, i.e. valid is high in the cycle after the push edge.
- Level update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Full (level = DEPTH):
  - tready = 0, so no push is possible.
  - A pop in that cycle reduces level to DEPTH-1; tready returns to 1 on the next edge.
- Empty (level = 0): tvalid = 0, so no pop. A push makes level = 1 and tvalid = 1 after the edge.
- Simultaneous push and pop at level 1 (a word in flight): the output advances to the new word, level stays 1, tvalid stays 1.
- Upstream protocol: the slave honours AXIS hold rules. tdata and tvalid are not checked for stability; the FIFO captures exactly what is present at the handshake edge.
- Master stability: once m_axis_tvalid_o is high with a given tdata, both stay unchanged until a pop. Pushes never alter the head word.
- Reset mid-operation: all stored words are discarded immediately and outputs return to their reset values asynchronously. No partial word survives.
- Ordering: strict FIFO; no reordering, duplication or loss.

Test Plan:
- Reset release with tvalid_i=0 -> first edge after release: tready_o=1, tvalid_o=0, level_o=0, tdata_o=0.
- Push 0x11,0x22,...,0x88 with m_axis_tready_i=0 (DEPTH=8) -> level_o steps 1..8; tready_o=0 after the 8th push; a 9th offered word 0x99 is not accepted; tvalid_o=1, tdata_o=0x11 throughout.
- From full, drive m_axis_tready_i=1 for 8 cycles, tvalid_i=0 -> output sequence 0x11..0x88 in order; level_o counts down to 0; tready_o=1 one edge after the first pop; tvalid_o=0 and tdata_o=0 at the end.
- Continuous streaming, tvalid_i=1 and m_axis_tready_i=1, 20 incrementing words 0x00..0x13 -> level_o stays 1 after the first edge, one word out per cycle, 1-cycle latency, pointers wrap twice with no loss.
- Random tvalid_i and m_axis_tready_i (~50% each) for 1000 cycles -> scoreboard matches in-order data; level_o equals the model count every cycle; tdata/tvalid are stable while stalled.
- Push 5 words, then assert arstn_i=0 mid-cycle with tready_i=0 -> immediately tvalid_o=0, level_o=0, tready_o=0. After release and one edge: tready_o=1 and no old words ever appear on the output.

Source files
------------

// File: rtl/axis_fifo_buf.sv
// axis_fifo_buf: first-word-fall-through AXI-Stream FIFO with a registered
// slave ready and a fill-level output. Pointers carry an extra wrap bit so
// that full and empty can be told apart without a separate counter.
module axis_fifo_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic [DATA_W-1:0]          s_axis_tdata_i,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    output logic [DATA_W-1:0]          m_axis_tdata_o,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // Storage is deliberately left out of reset; the pointers alone define
    // which words are live, so stale contents are never visible.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             tready_reg, tready_next;
    logic             push, pop;
    logic             full_next;
    logic [PTR_W-1:0] level;

    // Occupancy falls straight out of the wrap-bit pointers (0..DEPTH).
    assign level = wr_ptr_reg - rd_ptr_reg;

    assign push = s_axis_tvalid_i && tready_reg;
    assign pop  = m_axis_tvalid_o && m_axis_tready_i;

    // Next-pointer and next-ready computation; ready depends only on the
    // post-edge fill state, so there is no combinational ready path.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
        full_next   = (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                      (wr_ptr_next[AW] != rd_ptr_next[AW]);
        tready_next = !full_next;
    end

    // Pointer and ready-flag state; reset discards all stored words at once.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            tready_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            tready_reg <= tready_next;
        end
    end

    // Write port of the storage array.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= s_axis_tdata_i;
        end
    end

    // Head word is read combinationally so a word pushed at one edge is on
    // the master port right after that edge; data is forced to zero while
    // empty so the port never shows stale storage.
    assign m_axis_tvalid_o = (level != '0);
    assign m_axis_tdata_o  = m_axis_tvalid_o ? mem[rd_ptr_reg[AW-1:0]] : '0;
    assign s_axis_tready_o = tready_reg;
    assign level_o         = level;

endmodule

// File: tb/tb_axis_fifo_buf.sv
// Self-checking bench for axis_fifo_buf: a queue scoreboard holds every
// accepted word and is popped whenever the master handshake completes.
module tb_axis_fifo_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk_i;
    logic              arstn_i;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [LW-1:0]     level;

    int n_checks;
    int n_fail;
    logic [DATA_W-1:0] sb[$];

    axis_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .level_o         (level)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock of stimulus. Called 1 ns after a rising edge; samples the
    // outputs before the next edge, advances the scoreboard from the model's
    // own view of ready/valid, and returns 1 ns after that edge.
    task automatic clk_step(input logic v, input logic [DATA_W-1:0] d, input logic r,
                            output logic popped, output logic [DATA_W-1:0] exp_w,
                            output logic [DATA_W-1:0] got_w, output logic got_v);
        logic push_m;
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #1;
        got_w  = m_tdata;
        got_v  = m_tvalid;
        push_m = v && (sb.size() != DEPTH);
        popped = r && (sb.size() != 0);
        exp_w  = '0;
        @(posedge clk_i);
        if (popped) exp_w = sb.pop_front();
        if (push_m) sb.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        arstn_i  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || level !== '0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_hold got rdy=%b vld=%b lvl=%0d data=%h want 0 0 0 0",
                     s_tready, m_tvalid, level, m_tdata);
        end
        arstn_i = 1'b1;
        #1;
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b want 0 before first edge", s_tready);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || level !== '0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_first_edge got rdy=%b vld=%b lvl=%0d data=%h want 1 0 0 0",
                     s_tready, m_tvalid, level, m_tdata);
        end
        $display("reset released: rdy=%b vld=%b lvl=%0d", s_tready, m_tvalid, level);
    endtask

    task automatic test_fill();
        logic p, gv;
        logic [DATA_W-1:0] e, g;
        for (int i = 0; i < DEPTH; i++) begin
            clk_step(1'b1, DATA_W'(32'h11 * (i + 1)), 1'b0, p, e, g, gv);
            $display("push %h level=%0d", DATA_W'(32'h11 * (i + 1)), level);
            n_checks++;
            if (level !== LW'(i + 1) || m_tvalid !== 1'b1 || m_tdata !== 32'h11) begin
                n_fail++;
                $display("FAIL fill_step%0d got lvl=%0d vld=%b data=%h want %0d 1 00000011",
                         i, level, m_tvalid, m_tdata, i + 1);
            end
        end
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready got %b want 0", s_tready);
        end
        clk_step(1'b1, 32'h99, 1'b0, p, e, g, gv);
        $display("offer 99 while full: level=%0d", level);
        n_checks++;
        if (level !== LW'(DEPTH) || s_tready !== 1'b0 || m_tdata !== 32'h11 || sb.size() != DEPTH) begin
            n_fail++;
            $display("FAIL full_reject got lvl=%0d rdy=%b data=%h want 8 0 00000011",
                     level, s_tready, m_tdata);
        end
    endtask

    task automatic test_drain();
        logic p, gv;
        logic [DATA_W-1:0] e, g;
        for (int i = 0; i < DEPTH; i++) begin
            clk_step(1'b0, '0, 1'b1, p, e, g, gv);
            $display("pop %h level=%0d", g, level);
            n_checks++;
            if (!p || g !== e || e !== DATA_W'(32'h11 * (i + 1)) || level !== LW'(DEPTH - 1 - i)) begin
                n_fail++;
                $display("FAIL drain_step%0d got data=%h lvl=%0d want data=%h lvl=%0d",
                         i, g, level, DATA_W'(32'h11 * (i + 1)), DEPTH - 1 - i);
            end
            if (i == 0) begin
                n_checks++;
                if (s_tready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drain_ready_return got %b want 1", s_tready);
                end
            end
        end
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL drain_empty got vld=%b data=%h want 0 0", m_tvalid, m_tdata);
        end
    endtask

    task automatic test_stream();
        logic p, gv;
        logic [DATA_W-1:0] e, g;
        int outs;
        outs = 0;
        for (int i = 0; i <= 20; i++) begin
            clk_step(i < 20, DATA_W'(i), 1'b1, p, e, g, gv);
            if (p) begin
                $display("stream out %h", g);
                n_checks++;
                if (g !== e || e !== DATA_W'(outs)) begin
                    n_fail++;
                    $display("FAIL stream_data%0d got %h want %h", outs, g, outs);
                end
                outs++;
            end
            n_checks++;
            if (level !== ((i < 20) ? LW'(1) : LW'(0))) begin
                n_fail++;
                $display("FAIL stream_level%0d got %0d want %0d", i, level, (i < 20) ? 1 : 0);
            end
        end
        n_checks++;
        if (outs != 20) begin
            n_fail++;
            $display("FAIL stream_count got %0d want 20", outs);
        end
    endtask

    task automatic test_random();
        logic p, gv, prev_v, prev_p;
        logic [DATA_W-1:0] e, g, prev_d;
        prev_v = 1'b0;
        prev_p = 1'b0;
        prev_d = '0;
        for (int i = 0; i < 1000 + 20; i++) begin
            if (i < 1000)
                clk_step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)), p, e, g, gv);
            else
                clk_step(1'b0, '0, 1'b1, p, e, g, gv);
            if (prev_v && !prev_p) begin
                n_checks++;
                if (gv !== 1'b1 || g !== prev_d) begin
                    n_fail++;
                    $display("FAIL rand_stall%0d got vld=%b data=%h want 1 %h", i, gv, g, prev_d);
                end
            end
            if (p) begin
                $display("rand out %h", g);
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rand_data%0d got %h want %h", i, g, e);
                end
            end
            n_checks++;
            if (level !== LW'(sb.size()) || s_tready !== (sb.size() != DEPTH) ||
                m_tvalid !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_state%0d got lvl=%0d rdy=%b vld=%b want lvl=%0d",
                         i, level, s_tready, m_tvalid, sb.size());
            end
            prev_v = gv;
            prev_p = p;
            prev_d = g;
        end
    endtask

    task automatic test_reset_mid();
        logic p, gv;
        logic [DATA_W-1:0] e, g;
        for (int i = 0; i < 5; i++) clk_step(1'b1, DATA_W'(32'hA0 + i), 1'b0, p, e, g, gv);
        s_tvalid = 1'b0;
        #2;
        arstn_i = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if (m_tvalid !== 1'b0 || level !== '0 || s_tready !== 1'b0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL midreset_async got vld=%b lvl=%0d rdy=%b data=%h want 0 0 0 0",
                     m_tvalid, level, s_tready, m_tdata);
        end
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_release got rdy=%b vld=%b want 1 0", s_tready, m_tvalid);
        end
        for (int i = 0; i < 4; i++) begin
            clk_step(1'b0, '0, 1'b1, p, e, g, gv);
            n_checks++;
            if (gv !== 1'b0 || m_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_ghost%0d got vld=%b data=%h want 0", i, m_tvalid, m_tdata);
            end
        end
        clk_step(1'b1, 32'hABCD, 1'b1, p, e, g, gv);
        clk_step(1'b0, '0, 1'b1, p, e, g, gv);
        $display("post-reset out %h", g);
        n_checks++;
        if (!p || g !== 32'hABCD || e !== 32'hABCD) begin
            n_fail++;
            $display("FAIL midreset_fresh got %h want 0000abcd", g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
